// File: rtl/filter.sv
// 5x5 sliding-window convolution stage: one 5-pixel column per valid beat,
// one (sum of 25 products + bias) result per qualifying beat, two cycles later.
module filter #(
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DW-1:0]  d_in1,
    input  logic [DW-1:0]  d_in2,
    input  logic [DW-1:0]  d_in3,
    input  logic [DW-1:0]  d_in4,
    input  logic [DW-1:0]  d_in5,
    input  logic [25*DW-1:0] w_in,
    input  logic [DW-1:0]  b_in,
    input  logic           in_valid,
    output logic [DW-1:0]  d_out,
    output logic           out_valid
);

    // window element (row r, column c) lives at index 5*r+c; c=0 is the oldest column
    logic [DW-1:0] col      [5];
    logic [DW-1:0] win_q    [25];
    logic [DW-1:0] win_d    [25];
    logic [DW-1:0] prod_q   [25];
    logic [DW-1:0] prod_d   [25];
    logic [2:0]    cnt_q, cnt_d;
    logic          qual_d;
    logic          v1_q, v2_q;
    logic [DW-1:0] sum_d;
    logic [DW-1:0] d_out_q;
    logic          out_valid_q;

    assign col[0] = d_in1;
    assign col[1] = d_in2;
    assign col[2] = d_in3;
    assign col[3] = d_in4;
    assign col[4] = d_in5;

    always_comb begin
        for (int i = 0; i < 25; i++) begin
            win_d[i] = win_q[i];
        end
        if (in_valid) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[5*r+c] = win_q[5*r+c+1];
                end
                win_d[5*r+4] = col[r];
            end
        end
    end

    // count saturates at 5; the beat that reaches or stays at 5 qualifies
    always_comb begin
        cnt_d  = cnt_q;
        qual_d = in_valid && (cnt_q >= 3'd4);
        if (in_valid && (cnt_q != 3'd5)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // only the low DW bits of each product matter for the wrapped total
    always_comb begin
        for (int i = 0; i < 25; i++) begin
            prod_d[i] = win_q[i] * w_in[DW*i +: DW];
        end
    end

    always_comb begin
        sum_d = b_in;
        for (int i = 0; i < 25; i++) begin
            sum_d = sum_d + prod_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 25; i++) begin
                win_q[i]  <= '0;
                prod_q[i] <= '0;
            end
            cnt_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 25; i++) begin
                win_q[i]  <= win_d[i];
                prod_q[i] <= prod_d[i];
            end
            cnt_q       <= cnt_d;
            v1_q        <= qual_d;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                d_out_q <= sum_d;
            end
        end
    end

    assign d_out     = d_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_filter.sv
// Scoreboard bench for the 5x5 convolution stage: a column-history model
// predicts each result and its arrival cycle; a monitor checks every output.
module tb_filter;

    localparam int DW = 32;

    logic             clk;
    logic             rst_n;
    logic [DW-1:0]    d_in1, d_in2, d_in3, d_in4, d_in5;
    logic [25*DW-1:0] w_in;
    logic [DW-1:0]    b_in;
    logic             in_valid;
    logic [DW-1:0]    d_out;
    logic             out_valid;

    filter #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in1     (d_in1),
        .d_in2     (d_in2),
        .d_in3     (d_in3),
        .d_in4     (d_in4),
        .d_in5     (d_in5),
        .w_in      (w_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .d_out     (d_out),
        .out_valid (out_valid)
    );

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t              sbq[$];
    logic [4:0][31:0]  hist[$];
    int                wgt[5][5];
    int                bias;
    int                cyc;
    int                checks;
    int                errors;
    logic [31:0]       last_exp;
    exp_t              mon_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    // reference: sum over the last five valid columns (oldest = column 0)
    function automatic logic [31:0] ref_out();
        int acc;
        acc = bias;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++)
                acc += wgt[r][c] * int'(hist[c][r]);
        return acc;
    endfunction

    function automatic logic [4:0][31:0] splat(input logic [31:0] v);
        logic [4:0][31:0] x;
        for (int r = 0; r < 5; r++) x[r] = v;
        return x;
    endfunction

    task automatic apply_params();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w_in[DW*(5*r+c) +: DW] = wgt[r][c];
        b_in = bias;
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0][31:0] x);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        d_in1 = x[0]; d_in2 = x[1]; d_in3 = x[2]; d_in4 = x[3]; d_in5 = x[4];
        if (v) begin
            hist.push_back(x);
            if (hist.size() > 5) void'(hist.pop_front());
            if (hist.size() == 5) begin
                e.due = cyc + 3;
                e.val = ref_out();
                sbq.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, splat(32'h0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        hist.delete();
        last_exp = '0;
        #1;
        check_eq("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("reset_d_out", d_out, 32'h0);
        @(negedge clk);
        check_eq("reset_hold_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("reset_hold_d_out", d_out, 32'h0);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out_valid: got out_valid=1 d_out=%h at cycle %0d, required no output", d_out, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    last_exp = mon_e.val;
                    if (d_out !== mon_e.val || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL result: got %h at cycle %0d, required %h at cycle %0d", d_out, cyc, mon_e.val, mon_e.due);
                    end
                end
            end else begin
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_output: got out_valid=0 at cycle %0d, required %h due at cycle %0d", cyc, sbq[0].val, sbq[0].due);
                    void'(sbq.pop_front());
                end
                checks++;
                if (d_out !== last_exp) begin
                    errors++;
                    $display("FAIL d_out_hold: got %h at cycle %0d, required %h", d_out, cyc, last_exp);
                end
            end
        end
    end

    initial begin
        logic [4:0][31:0] x;
        checks = 0;
        errors = 0;
        last_exp = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        {d_in1, d_in2, d_in3, d_in4, d_in5} = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                wgt[r][c] = c + 1;
        bias = 1;
        apply_params();
        repeat (2) @(negedge clk);

        // all ones: no output for beats 1-4, then 76
        do_reset();
        for (int j = 0; j < 4; j++) drive(1'b1, splat(32'd1));
        idle(3);
        drive(1'b1, splat(32'd1));
        idle(4);
        check_eq("ones", d_out, 32'd76);

        // column j carries j+1
        do_reset();
        for (int j = 0; j < 5; j++) drive(1'b1, splat(j + 1));
        idle(4);
        check_eq("ramp", d_out, 32'h114);

        // signed: all -1
        do_reset();
        for (int j = 0; j < 5; j++) drive(1'b1, splat(32'hFFFFFFFF));
        idle(4);
        check_eq("neg_ones", d_out, 32'hFFFFFFB6);

        // wraparound with max positive bias
        bias = 32'h7FFFFFFF;
        apply_params();
        do_reset();
        for (int j = 0; j < 5; j++) drive(1'b1, splat(32'd1));
        idle(4);
        check_eq("wrap", d_out, 32'h8000004A);
        for (int j = 0; j < 5; j++) drive(1'b1, splat(32'd0));
        idle(4);
        check_eq("zeros_bias", d_out, 32'h7FFFFFFF);

        // alternating valid, incrementing pixels distinct per row
        bias = 1;
        apply_params();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            for (int r = 0; r < 5; r++) x[r] = 5 * k + r;
            drive(1'b1, x);
            idle(1);
        end
        idle(4);

        // reset mid-fill: restart needs five fresh beats
        do_reset();
        for (int j = 0; j < 3; j++) drive(1'b1, splat(32'd9));
        do_reset();
        for (int j = 0; j < 4; j++) drive(1'b1, splat(32'd2));
        idle(3);
        drive(1'b1, splat(32'd2));
        idle(4);
        check_eq("after_reset", d_out, 32'd151);

        // random weights, bias, pixels and valid pattern, with a reset mid-stream
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                wgt[r][c] = $urandom;
        bias = $urandom;
        apply_params();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            for (int r = 0; r < 5; r++) x[r] = $urandom;
            drive($urandom_range(0, 3) != 0, x);
        end
        idle(5);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d undelivered results, required 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter.md
Name: filter

Overview:
- 5x5 convolution filter stage of the CNN datapath.
- Each valid beat delivers one new 5-pixel column (d_in1 = top row … d_in5 = bottom row) into a 5-column sliding window.
- Once the window is full, every valid beat produces one output: the sum of the 25 window pixels times the 25 weights, plus a bias.
- Sits between the line-buffer/column feeder and the activation/pooling stage.

Parameters:
- DW, 32, data, weight, bias and output word width. All arithmetic is two's-complement signed.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- d_in1  in  DW  column pixel, row 0 (top).
- d_in2  in  DW  column pixel, row 1.
- d_in3  in  DW  column pixel, row 2.
- d_in4  in  DW  column pixel, row 3.
- d_in5  in  DW  column pixel, row 4 (bottom).
- w_in  in  25*DW  weights; w_in[DW*(5*r+c) +: DW] = weight for row r (0..4), window column c (0 = oldest column, 4 = newest).
- b_in  in  DW  bias, added once per output.
- in_valid  in  1  column beat qualifier.
- d_out  out  DW  convolution result.
- out_valid  out  1  one-cycle strobe, d_out valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All registers clear immediately when rst_n=0.
- Reset values: window = 0, column count = 0, pipeline = 0, d_out = 0, out_valid = 0.
- Window:
  - On each clk edge with in_valid=1, columns shift: c0<=c1, c1<=c2, c2<=c3, c3<=c4, c4<={d_in1..d_in5}.
  - When in_valid=0, the window holds.
  - Gaps between beats are allowed; only valid beats count.
- Column counter: 3 bits, increments on each valid beat, saturates at 5. A beat is "qualifying" when it makes or keeps the count at 5, i.e. the 5th valid beat after reset and every valid beat thereafter.
- Pipeline for a qualifying beat sampled at edge k:
  - edge k: window updated, qualifier flag registered.
  - edge k+1: 25 products w[r][c]*x[r][c] registered.
  - edge k+2: d_out <= (sum of 25 products + b_in), out_valid <= 1.
  - Latency is 2 cycles from the sampling edge to the output edge. Throughput is one result per clock.
  - Back-to-back qualifying beats give back-to-back out_valid pulses.
- Non-qualifying edges: out_valid <= 0 on any edge whose stage-2 flag is 0. d_out holds its last value.
- Arithmetic:
  - Products and sum are computed modulo 2^DW; d_out is the low DW bits. Overflow wraps silently, with no saturation.
  - Equivalently, full-width products may be computed, as long as the low DW bits of the total are returned.
- Operand timing: w_in is used at the product stage and b_in at the sum stage. Both must be held static while data streams; changing them mid-stream affects in-flight results.
- No row/frame boundary handling: the window slides continuously. Upstream inserts a reset to restart the fill.
- Reset mid-operation: in-flight results are discarded, out_valid goes to 0 immediately, and the count restarts. The next output needs 5 new valid beats.
- in_valid=X/unknown before reset release is ignored because the logic is held in reset.

Test Plan:
- Weights per row {c0..c4} = {1,2,3,4,5}, b_in=1, five beats with all pixels = 1 -> single out_valid pulse 2 cycles after 5th beat, d_out = 76 (0x0000004C). No pulse for beats 1–4.
- Same weights, beat j (j=0..4) carries value j+1 on all rows -> d_out = 5*(1+4+9+16+25)+1 = 276 (0x114).
- All pixels = -1 (0xFFFFFFFF), same weights, b_in=1 -> d_out = -74 (0xFFFFFFB6), checks signed math.
- b_in=0x7FFFFFFF, all pixels 1, same weights -> d_out = 0x8000004A (wrap). All pixels 0 -> 0x7FFFFFFF.
- in_valid toggling every cycle with incrementing pixels -> window advances only on valid beats. Outputs match a software 5-column model and arrive 2 cycles after each qualifying beat; out_valid low on the alternate cycles.
- Assert rst_n=0 after 3 beats of a stream, release, then send 4 beats -> no out_valid. The 5th beat gives exactly one correct output; out_valid=0 and d_out=0 during reset.
